wb_sequencer: RTL and testbench



---
 rtl/wb_pkg.sv | 30 +++
 rtl/wb_sequencer.sv | 85 ++++++++
 tb/tb_wb_sequencer.sv | 128 ++++++++++++
 3 files changed

// File: rtl/wb_pkg.sv
// wb_pkg: shared encodings, select codes, state enum and select decode for the write-back sequencer.
package wb_pkg;
  typedef enum logic [2:0] {
    WB_NONE, WB_RTYPE, WB_ITYPE, WB_LOAD, WB_JAL, WB_JALR, WB_MFHI, WB_MFLO
  } wb_kind_e;

  localparam logic [1:0] RD_RT = 2'b00;
  localparam logic [1:0] RD_RD = 2'b01;
  localparam logic [1:0] RD_31 = 2'b10;

  localparam logic [2:0] WD_ALU = 3'b000;
  localparam logic [2:0] WD_MDR = 3'b001;
  localparam logic [2:0] WD_PC  = 3'b010;
  localparam logic [2:0] WD_HI  = 3'b011;
  localparam logic [2:0] WD_LO  = 3'b100;

  typedef enum logic [1:0] {S_IDLE, S_MEM_WAIT, S_WRITE, S_FINISH} state_e;

  function automatic logic [1:0] rd_sel(input logic [2:0] k);
    return (k == WB_JAL) ? RD_31 :
           (k == WB_RTYPE || k == WB_JALR || k == WB_MFHI || k == WB_MFLO) ? RD_RD : RD_RT;
  endfunction

  function automatic logic [2:0] wd_sel(input logic [2:0] k);
    return (k == WB_LOAD) ? WD_MDR :
           (k == WB_JAL || k == WB_JALR) ? WD_PC :
           (k == WB_MFHI) ? WD_HI :
           (k == WB_MFLO) ? WD_LO : WD_ALU;
  endfunction
endpackage

// File: rtl/wb_sequencer.sv
// wb_sequencer: register-file write-back sequencer; drives dest/data selects, reg_write strobe and done pulse.
module wb_sequencer
  import wb_pkg::*;
#(
  parameter int MEM_LATENCY = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [2:0] wb_kind,
  input  logic [4:0] inst20_16,
  input  logic [4:0] inst15_11,
  input  logic       abort,
  output logic [1:0] mux_regDest_control,
  output logic [2:0] mux_wd_control,
  output logic       reg_write,
  output logic       busy,
  output logic       done
);
  localparam logic [3:0] LAT_M1 = 4'((MEM_LATENCY > 0) ? MEM_LATENCY - 1 : 0);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [1:0] rdsel_q, rdsel_d;
  logic [2:0] wdsel_q, wdsel_d;
  logic [4:0] rt_q, rt_d, rd_q, rd_d;
  logic [4:0] dest;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdsel_d = rdsel_q;
    wdsel_d = wdsel_q;
    rt_d    = rt_q;
    rd_d    = rd_q;
    unique case (state_q)
      S_IDLE: if (start && !abort) begin
        rt_d    = inst20_16;
        rd_d    = inst15_11;
        rdsel_d = rd_sel(wb_kind);
        wdsel_d = wd_sel(wb_kind);
        cnt_d   = LAT_M1;
        state_d = (wb_kind == WB_NONE) ? S_FINISH :
                  (wb_kind == WB_LOAD && MEM_LATENCY > 0) ? S_MEM_WAIT : S_WRITE;
      end
      S_MEM_WAIT: begin
        state_d = abort ? S_IDLE : (cnt_q == 4'd0) ? S_WRITE : S_MEM_WAIT;
        cnt_d   = (cnt_q == 4'd0) ? cnt_q : cnt_q - 4'd1;
      end
      S_WRITE:  state_d = S_FINISH;
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    // selects are only meaningful while a job is in flight
    if (state_d == S_IDLE) begin
      rdsel_d = RD_RT;
      wdsel_d = WD_ALU;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rdsel_q <= '0;
      wdsel_q <= '0;
      rt_q    <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdsel_q <= rdsel_d;
      wdsel_q <= wdsel_d;
      rt_q    <= rt_d;
      rd_q    <= rd_d;
    end
  end

  assign dest                = (rdsel_q == RD_RD) ? rd_q : (rdsel_q == RD_31) ? 5'd31 : rt_q;
  assign reg_write           = (state_q == S_WRITE) && (dest != 5'd0);
  assign done                = (state_q == S_FINISH);
  assign busy                = (state_q != S_IDLE);
  assign mux_regDest_control = rdsel_q;
  assign mux_wd_control      = wdsel_q;
endmodule

// File: tb/tb_wb_sequencer.sv
// tb_wb_sequencer: directed checks of wb_sequencer at MEM_LATENCY 2, plus 0 and 15 for load timing.
module tb_wb_sequencer;
  logic       clk = 0, reset = 1, start = 0, abort = 0;
  logic [2:0] wb_kind = 0;
  logic [4:0] rt = 0, rd = 0;
  logic [1:0] rds2, rds0, rds15;
  logic [2:0] wds2, wds0, wds15;
  logic       rw2, rw0, rw15, bz2, bz0, bz15, dn2, dn0, dn15;
  int         n_chk = 0, n_pass = 0;

  always #5 clk = ~clk;

  wb_sequencer #(.MEM_LATENCY(2)) u2 (
    .clk(clk), .reset(reset), .start(start), .wb_kind(wb_kind), .inst20_16(rt), .inst15_11(rd),
    .abort(abort), .mux_regDest_control(rds2), .mux_wd_control(wds2), .reg_write(rw2), .busy(bz2), .done(dn2));
  wb_sequencer #(.MEM_LATENCY(0)) u0 (
    .clk(clk), .reset(reset), .start(start), .wb_kind(wb_kind), .inst20_16(rt), .inst15_11(rd),
    .abort(abort), .mux_regDest_control(rds0), .mux_wd_control(wds0), .reg_write(rw0), .busy(bz0), .done(dn0));
  wb_sequencer #(.MEM_LATENCY(15)) u15 (
    .clk(clk), .reset(reset), .start(start), .wb_kind(wb_kind), .inst20_16(rt), .inst15_11(rd),
    .abort(abort), .mux_regDest_control(rds15), .mux_wd_control(wds15), .reg_write(rw15), .busy(bz15), .done(dn15));

  wire [7:0] o2 = {rds2, wds2, rw2, bz2, dn2};

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] k, input logic [4:0] t, input logic [4:0] d);
    wb_kind = k; rt = t; rd = d; start = 1;
    step();
    start = 0;
  endtask

  initial begin
    step(); step();
    chk("reset_u2", o2, 8'b00_000_000);
    chk("reset_u0", {rds0, wds0, rw0, bz0, dn0}, 8'b0);
    chk("reset_u15", {rds15, wds15, rw15, bz15, dn15}, 8'b0);
    reset = 0;
    step();
    chk("idle", o2, 8'b0);

    issue(3'd1, 5'd3, 5'd8);
    chk("rtype_n1", o2, 8'b01_000_110);
    step(); chk("rtype_n2", o2, 8'b01_000_011);
    step(); chk("rtype_n3", o2, 8'b00_000_000);

    issue(3'd3, 5'd5, 5'd0);
    chk("load_n1", o2, 8'b00_001_010);
    wb_kind = 3'd1; rd = 5'd8; start = 1;
    step(); chk("load_n2", o2, 8'b00_001_010);
    step(); start = 0;
    chk("load_n3", o2, 8'b00_001_110);
    step(); chk("load_n4", o2, 8'b00_001_011);
    step(); chk("load_n5", o2, 8'b0);
    step(); chk("load_no_queue", o2, 8'b0);

    issue(3'd4, 5'd7, 5'd9);
    chk("jal_n1", o2, 8'b10_010_110);
    step(); chk("jal_n2", o2, 8'b10_010_011);
    step();

    issue(3'd2, 5'd0, 5'd12);
    chk("itype_r0_n1", o2, 8'b00_000_010);
    step(); chk("itype_r0_n2", o2, 8'b00_000_011);
    step(); chk("itype_r0_n3", o2, 8'b0);

    issue(3'd0, 5'd4, 5'd4);
    chk("none_n1", o2, 8'b00_000_011);
    step(); chk("none_n2", o2, 8'b0);

    issue(3'd6, 5'd1, 5'd2);
    chk("mfhi_n1", o2, 8'b01_011_110);
    step(); step();

    issue(3'd3, 5'd5, 5'd0);
    chk("ldab_n1", o2, 8'b00_001_010);
    step(); abort = 1;
    chk("ldab_n2", o2, 8'b00_001_010);
    step(); abort = 0;
    chk("ldab_n3", o2, 8'b0);
    step(); chk("ldab_n4", o2, 8'b0);

    abort = 1;
    issue(3'd1, 5'd3, 5'd8);
    abort = 0;
    chk("start_abort", o2, 8'b0);
    step(); chk("start_abort2", o2, 8'b0);

    issue(3'd1, 5'd3, 5'd4);
    chk("rst_write_n1", o2, 8'b01_000_110);
    reset = 1;
    step(); chk("rst_write_n2", o2, 8'b0);
    reset = 0;
    step(); chk("rst_write_n3", o2, 8'b0);

    issue(3'd1, 5'd3, 5'd8);
    chk("b2b_n1", o2, 8'b01_000_110);
    step(); chk("b2b_fin", o2, 8'b01_000_011);
    wb_kind = 3'd7; rt = 5'd1; rd = 5'd6; start = 1;
    step(); chk("b2b_fin_ignores", o2, 8'b0);
    step(); start = 0;
    chk("mflo_n1", o2, 8'b01_100_110);
    step(); chk("mflo_n2", o2, 8'b01_100_011);
    step();

    reset = 1; step(); step(); reset = 0; step();
    issue(3'd3, 5'd5, 5'd0);
    for (int k = 1; k <= 18; k++) begin
      chk($sformatf("lat0_c%0d", k), {7'b0, rw0}, {7'b0, k == 1});
      chk($sformatf("lat2_c%0d", k), {7'b0, rw2}, {7'b0, k == 3});
      chk($sformatf("lat15_c%0d", k), {7'b0, rw15}, {7'b0, k == 16});
      if (k == 17) chk("lat15_done", {7'b0, dn15}, 8'd1);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
